// File: rtl/qdec_position_ctrl_pkg.sv
// Shared types and default widths for the quadrature position/homing blocks.
package qdec_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int POS_W_DEF = 16;
    localparam int VEL_W_DEF = 12;

    // Homing sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEEK = 2'd1,
        ZERO = 2'd2,
        ERR  = 2'd3
    } home_state_t;

    // Per-cycle count change; only -1, 0 and +1 are legal.
    typedef logic signed [1:0] delta_t;

endpackage

// File: rtl/qdec_position_ctrl_if.sv
// Command/status bundle between motion logic and the position controller.
interface qdec_position_ctrl_if import qdec_pkg::*; #(
    parameter int POS_W = POS_W_DEF,
    parameter int VEL_W = VEL_W_DEF
) ();

    logic                    home_req;
    logic                    home_dir;
    logic                    abort;
    logic                    motor_en;
    logic                    motor_dir;
    logic signed [POS_W-1:0] position;
    logic signed [VEL_W-1:0] velocity;
    logic                    vel_valid;
    logic                    homed;
    logic                    home_busy;
    logic                    home_err;

    // Motion logic side: issues homing commands, consumes position/status.
    modport master (
        output home_req, home_dir, abort,
        input  motor_en, motor_dir, position, velocity, vel_valid,
               homed, home_busy, home_err
    );

    // Controller side.
    modport slave (
        input  home_req, home_dir, abort,
        output motor_en, motor_dir, position, velocity, vel_valid,
               homed, home_busy, home_err
    );

endinterface

// File: rtl/qdec_idx_sync.sv
// Two-flop synchronizer for the asynchronous Z channel plus rising-edge detect.
module qdec_idx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic index,
    output logic idx_rise
);

    logic [1:0] sync_reg;
    logic       prev_reg;

    // Shift the raw index through two stages, remember the last synced value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], index};
            prev_reg <= sync_reg[1];
        end
    end

    assign idx_rise = sync_reg[1] & ~prev_reg;

endmodule

// File: rtl/qdec_position_ctrl.sv
// Extends the wrapping decoder count into absolute position, measures windowed
// velocity and sequences homing onto the index mark.
module qdec_position_ctrl import qdec_pkg::*; #(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int POS_W   = POS_W_DEF,
    parameter int VEL_W   = VEL_W_DEF,
    parameter int VEL_WIN = 1000,
    parameter int HOME_TO = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] enc_cnt,
    input  logic             index,
    qdec_position_ctrl_if.slave bus
);

    localparam int WIN_W   = $clog2(VEL_WIN);
    localparam int TO_W    = $clog2(HOME_TO + 1);
    localparam int VEL_MAX = 2 ** (VEL_W - 1) - 1;

    logic [CNT_W-1:0]        enc_q_reg;
    logic                    primed_reg;
    delta_t                  delta;
    logic signed [POS_W-1:0] position_reg;
    logic signed [31:0]      acc_reg;
    logic signed [31:0]      acc_sum;
    logic [WIN_W-1:0]        win_reg;
    logic signed [VEL_W-1:0] velocity_reg;
    logic signed [VEL_W-1:0] vel_sat;
    logic                    vel_valid_reg;
    logic                    idx_rise;

    home_state_t             state_reg, state_next;
    logic                    dir_reg, dir_next;
    logic                    homed_reg, homed_next;
    logic                    err_reg, err_next;
    logic [TO_W-1:0]         to_reg, to_next;

    qdec_idx_sync u_idx_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .index    (index),
        .idx_rise (idx_rise)
    );

    // Low bits of the modular difference are enough: legal steps are 0, +1, -1.
    assign delta   = delta_t'(enc_cnt - enc_q_reg);
    assign acc_sum = acc_reg + 32'(delta);

    // Clamp the window sum symmetrically into the velocity range.
    always_comb begin
        vel_sat = VEL_W'(acc_sum);
        if (acc_sum > VEL_MAX) begin
            vel_sat = VEL_W'(VEL_MAX);
        end else if (acc_sum < -VEL_MAX) begin
            vel_sat = VEL_W'(-VEL_MAX);
        end
    end

    // Previous-count register and position; first cycle after reset only primes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_q_reg    <= '0;
            primed_reg   <= 1'b0;
            position_reg <= '0;
        end else begin
            enc_q_reg  <= enc_cnt;
            primed_reg <= 1'b1;
            if (state_reg == ZERO) begin
                position_reg <= '0;
            end else if (primed_reg) begin
                position_reg <= position_reg + POS_W'(delta);
            end
        end
    end

    // Velocity window: publish the sum including the last cycle, then restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg       <= '0;
            win_reg       <= '0;
            velocity_reg  <= '0;
            vel_valid_reg <= 1'b0;
        end else begin
            vel_valid_reg <= 1'b0;
            if (primed_reg) begin
                if (win_reg == WIN_W'(VEL_WIN - 1)) begin
                    velocity_reg  <= vel_sat;
                    vel_valid_reg <= 1'b1;
                    acc_reg       <= '0;
                    win_reg       <= '0;
                end else begin
                    acc_reg <= acc_sum;
                    win_reg <= win_reg + WIN_W'(1);
                end
            end
        end
    end

    // Homing state and its side registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            dir_reg   <= 1'b0;
            homed_reg <= 1'b0;
            err_reg   <= 1'b0;
            to_reg    <= '0;
        end else begin
            state_reg <= state_next;
            dir_reg   <= dir_next;
            homed_reg <= homed_next;
            err_reg   <= err_next;
            to_reg    <= to_next;
        end
    end

    // Homing next-state: abort beats index, index beats timeout.
    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        homed_next = homed_reg;
        err_next   = err_reg;
        to_next    = to_reg;
        case (state_reg)
            IDLE: begin
                if (bus.home_req) begin
                    state_next = SEEK;
                    dir_next   = bus.home_dir;
                    homed_next = 1'b0;
                    err_next   = 1'b0;
                    to_next    = '0;
                end
            end
            SEEK: begin
                to_next = to_reg + TO_W'(1);
                if (bus.abort) begin
                    state_next = IDLE;
                    homed_next = 1'b0;
                end else if (idx_rise) begin
                    state_next = ZERO;
                end else if (to_reg == TO_W'(HOME_TO - 1)) begin
                    state_next = ERR;
                    err_next   = 1'b1;
                end
            end
            ZERO: begin
                state_next = IDLE;
                homed_next = 1'b1;
            end
            ERR: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (bus.home_req) begin
                    state_next = SEEK;
                    dir_next   = bus.home_dir;
                    homed_next = 1'b0;
                    err_next   = 1'b0;
                    to_next    = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.motor_en  = (state_reg == SEEK);
    assign bus.motor_dir = dir_reg;
    assign bus.position  = position_reg;
    assign bus.velocity  = velocity_reg;
    assign bus.vel_valid = vel_valid_reg;
    assign bus.homed     = homed_reg;
    assign bus.home_busy = (state_reg == SEEK) || (state_reg == ZERO);
    assign bus.home_err  = err_reg;

endmodule

// File: tb/tb_qdec_position_ctrl.sv
// Directed bench for qdec_position_ctrl: one instance for position/velocity/homing,
// a second narrow-velocity, short-timeout instance for saturation and timeout.
module tb_qdec_position_ctrl;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] enc_a = 8'h7F;
    logic [7:0] enc_b = 8'h00;
    logic       index_a = 1'b0;
    logic       index_b = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    qdec_position_ctrl_if #(.POS_W(16), .VEL_W(12)) bus_a ();
    qdec_position_ctrl_if #(.POS_W(16), .VEL_W(4))  bus_b ();

    qdec_position_ctrl #(
        .CNT_W(8), .POS_W(16), .VEL_W(12), .VEL_WIN(100), .HOME_TO(100)
    ) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .enc_cnt (enc_a),
        .index   (index_a),
        .bus     (bus_a.slave)
    );

    qdec_position_ctrl #(
        .CNT_W(8), .POS_W(16), .VEL_W(4), .VEL_WIN(20), .HOME_TO(20)
    ) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .enc_cnt (enc_b),
        .index   (index_b),
        .bus     (bus_b.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d (0x%h), expected %0d (0x%h)", tag, obs, obs, exp, exp);
        end else begin
            $display("[TB] ok   %s = 0x%h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Step enc_b every cycle until two velocity updates; return the second.
    task automatic run_b(input int step, output logic [31:0] v, output int ok);
        int pulses;
        pulses = 0;
        v = '0;
        for (int i = 0; i < 100 && pulses < 2; i++) begin
            enc_b = enc_b + step[7:0];
            tick();
            if (bus_b.vel_valid) begin
                pulses++;
                v = bus_b.velocity;
            end
        end
        ok = (pulses == 2) ? 1 : 0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          found;
        int          pulses;
        int          ok;
        logic [31:0] v;

        bus_a.home_req = 1'b0; bus_a.home_dir = 1'b0; bus_a.abort = 1'b0;
        bus_b.home_req = 1'b0; bus_b.home_dir = 1'b0; bus_b.abort = 1'b0;

        // Reset state
        #23;
        check("rst_position",  bus_a.position,  0);
        check("rst_velocity",  bus_a.velocity,  0);
        check("rst_vel_valid", bus_a.vel_valid, 0);
        check("rst_motor_en",  bus_a.motor_en,  0);
        check("rst_motor_dir", bus_a.motor_dir, 0);
        check("rst_homed",     bus_a.homed,     0);
        check("rst_busy",      bus_a.home_busy, 0);
        check("rst_err",       bus_a.home_err,  0);

        // Post-reset: no jump from 0 to 0x7F, then +1
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) tick();
        check("hold_pos", bus_a.position, 0);
        enc_a = 8'h80;
        tick();
        check("step_pos", bus_a.position, 1);

        // Forward wrap from 0xF0 over 300 steps
        rst_n = 1'b0;
        enc_a = 8'hF0;
        tick();
        check("rerst_pos", bus_a.position, 0);
        rst_n = 1'b1;
        tick();
        tick();
        for (int i = 1; i <= 300; i++) begin
            enc_a = enc_a + 8'd1;
            tick();
            if (i == 16) check("wrap_ff_to_00", bus_a.position, 16);
        end
        check("fwd_pos", bus_a.position, 300);

        // Velocity: align to a window boundary, then +1 every 4 cycles
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            tick();
            if (bus_a.vel_valid) found = 1;
        end
        check("vel_sync", found, 1);
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            if (i % 4 == 0) enc_a = enc_a + 8'd1;
            tick();
            if (bus_a.vel_valid) pulses++;
        end
        check("vel_value",  bus_a.velocity, 25);
        check("vel_pulses", pulses, 1);
        check("vel_pos",    bus_a.position, 325);

        // Homing, reverse direction, index 50 cycles after request
        bus_a.home_dir = 1'b0;
        bus_a.home_req = 1'b1;
        tick();
        bus_a.home_req = 1'b0;
        check("seek_en",   bus_a.motor_en,  1);
        check("seek_dir",  bus_a.motor_dir, 0);
        check("seek_busy", bus_a.home_busy, 1);
        repeat (49) tick();
        check("seek_hold_en", bus_a.motor_en, 1);
        index_a = 1'b1;
        tick();
        tick();
        check("pre_zero_homed", bus_a.homed, 0);
        tick();
        check("zero_en",        bus_a.motor_en, 0);
        check("zero_pos_still", bus_a.position, 325);
        tick();
        check("home_pos",   bus_a.position,  0);
        check("homed",      bus_a.homed,     1);
        check("home_idle",  bus_a.home_busy, 0);

        // Index outside SEEK must not re-zero
        index_a = 1'b0;
        repeat (3) begin
            enc_a = enc_a + 8'd1;
            tick();
        end
        index_a = 1'b1;
        repeat (5) tick();
        check("idx_idle_pos",   bus_a.position, 3);
        check("idx_idle_homed", bus_a.homed,    1);
        index_a = 1'b0;
        repeat (3) tick();

        // Abort in the same cycle as idx_rise
        bus_a.home_dir = 1'b1;
        bus_a.home_req = 1'b1;
        tick();
        bus_a.home_req = 1'b0;
        check("abort_seek_dir", bus_a.motor_dir, 1);
        check("seek_homed_clr", bus_a.homed,     0);
        repeat (3) tick();
        index_a = 1'b1;
        tick();
        tick();
        bus_a.abort = 1'b1;
        tick();
        bus_a.abort = 1'b0;
        check("abort_busy",  bus_a.home_busy, 0);
        check("abort_en",    bus_a.motor_en,  0);
        check("abort_homed", bus_a.homed,     0);
        tick();
        check("abort_pos",      bus_a.position,  3);
        check("abort_dir_hold", bus_a.motor_dir, 1);
        index_a = 1'b0;

        // Velocity saturation on the 4-bit instance
        run_b(1, v, ok);
        check("sat_pos_seen", ok, 1);
        check("sat_pos",      v,  7);
        run_b(-1, v, ok);
        check("sat_neg_seen", ok, 1);
        check("sat_neg",      v,  32'hFFFF_FFF9);

        // Timeout after 20 SEEK cycles, then retry
        bus_b.home_dir = 1'b1;
        bus_b.home_req = 1'b1;
        tick();
        bus_b.home_req = 1'b0;
        check("to_seek_en",  bus_b.motor_en,  1);
        check("to_seek_dir", bus_b.motor_dir, 1);
        repeat (19) tick();
        check("to_pre_en",  bus_b.motor_en, 1);
        check("to_pre_err", bus_b.home_err, 0);
        tick();
        check("to_err",      bus_b.home_err,  1);
        check("to_en",       bus_b.motor_en,  0);
        check("to_dir_hold", bus_b.motor_dir, 1);
        bus_b.home_req = 1'b1;
        tick();
        bus_b.home_req = 1'b0;
        check("retry_err",  bus_b.home_err,  0);
        check("retry_en",   bus_b.motor_en,  1);
        check("retry_busy", bus_b.home_busy, 1);
        repeat (20) tick();
        check("retry_to_err", bus_b.home_err, 1);
        bus_b.abort = 1'b1;
        tick();
        bus_b.abort = 1'b0;
        check("err_abort_keep", bus_b.home_err, 1);

        // Asynchronous reset during SEEK
        bus_a.home_req = 1'b1;
        tick();
        bus_a.home_req = 1'b0;
        repeat (2) tick();
        check("rst_pre_en", bus_a.motor_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_en",   bus_a.motor_en,  0);
        check("rst_async_busy", bus_a.home_busy, 0);
        check("rst_async_pos",  bus_a.position,  0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
